// File: rtl/gf2m_ld2affine233.sv
`default_nettype none
// ============================================================================
//  Module      : gf2m_ld2affine233 (plus squerer_233, gf2m_mult233,
//                gf2m_inv233)
//  Description : Converts a GF(2^233) Lopez-Dahab projective point (X, Y, Z)
//                into affine coordinates x = X/Z, y = Y/Z^2.
//                Field polynomial f(t) = t^233 + t^74 + 1.
//  Ports (top) : clk, rst        - clock, synchronous active-high reset
//                in_valid/in_ready, X, Y, Z       - projective point input
//                out_valid/out_ready, x_aff, y_aff, inf - affine result
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  squerer_233 : combinational squaring mod t^233 + t^74 + 1
//  Ports       : a  - operand
//                sq - a^2 mod f
// ----------------------------------------------------------------------------
module squerer_233 (
  input  logic [232:0] a,
  output logic [232:0] sq
);

  function automatic logic [232:0] gf_sqr(input logic [232:0] v);
    logic [464:0] d;
    d = '0;
    // Squaring over GF(2) just interleaves zeros between the operand bits.
    for (int i = 0; i < 233; i++) begin
      d[2*i] = v[i];
    end
    // Fold from the top down: t^k = t^(k-233) * (t^74 + 1).
    for (int i = 464; i >= 233; i--) begin
      if (d[i]) begin
        d[i-233] = ~d[i-233];
        d[i-159] = ~d[i-159];
      end
    end
    return d[232:0];
  endfunction

  assign sq = gf_sqr(a);

endmodule

// ----------------------------------------------------------------------------
//  gf2m_mult233 : GF(2^233) multiplier with LAT output register stages
//  Ports        : clk  - clock
//                 a, b - operands (expected to be held stable by the caller)
//                 p    - a*b mod f, valid LAT cycles after operands settle
// ----------------------------------------------------------------------------
module gf2m_mult233 #(
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic [232:0] a,
  input  logic [232:0] b,
  output logic [232:0] p
);

  localparam logic [232:0] c_POLY_LOW = {158'd0, 1'b1, 73'd0, 1'b1};

  // Interleaved shift-and-add: sh walks through a*t^i already reduced.
  function automatic logic [232:0] gf_mul(input logic [232:0] x,
                                          input logic [232:0] y);
    logic [232:0] acc;
    logic [232:0] sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < 233; i++) begin
      if (y[i]) begin
        acc = acc ^ sh;
      end
      sh = {sh[231:0], 1'b0} ^ (sh[232] ? c_POLY_LOW : 233'd0);
    end
    return acc;
  endfunction

  logic [232:0] r_pipe [LAT];

  always_ff @(posedge clk) begin
    r_pipe[0] <= gf_mul(a, b);
    for (int i = 1; i < LAT; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign p = r_pipe[LAT-1];

endmodule

// ----------------------------------------------------------------------------
//  gf2m_inv233 : Fermat inverter, a^-1 = a^(2^233 - 2)
//  Ports       : clk, rst - clock, synchronous active-high reset
//                start    - level request; hold high until done
//                a        - operand, sampled when a request is accepted
//                done     - result valid; stays high while start is high and
//                           for one cycle after start drops
//                inv      - a^-1 (0 for a == 0)
// ----------------------------------------------------------------------------
module gf2m_inv233 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [232:0] a,
  output logic         done,
  output logic [232:0] inv
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } inv_state_t;

  // a^(2^233-2) = prod_{i=1..232} a^(2^i): 232 square-and-multiply steps.
  localparam logic [7:0] c_LAST_STEP = 8'd231;

  inv_state_t   r_state;
  inv_state_t   w_next;
  logic [232:0] r_s;      // running a^(2^i)
  logic [232:0] r_r;      // running product
  logic [7:0]   r_cnt;
  logic [232:0] w_sq;
  logic [232:0] w_p;

  squerer_233 u_sq (
    .a  (r_s),
    .sq (w_sq)
  );

  // Operands r_r and sq(r_s) stay fixed across S_MUL so the registered
  // product is valid during S_STEP.
  gf2m_mult233 #(
    .LAT (1)
  ) u_mul (
    .clk (clk),
    .a   (r_r),
    .b   (w_sq),
    .p   (w_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_MUL;
        end
      end
      S_MUL: begin
        w_next = start ? S_STEP : S_IDLE;
      end
      S_STEP: begin
        if (!start) begin
          w_next = S_IDLE;
        end else if (r_cnt == c_LAST_STEP) begin
          w_next = S_DONE;
        end else begin
          w_next = S_MUL;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_s   <= a;
            r_r   <= 233'd1;
            r_cnt <= '0;
          end
        end
        S_STEP: begin
          r_r   <= w_p;
          r_s   <= w_sq;
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign inv = r_r;

endmodule

// ----------------------------------------------------------------------------
//  gf2m_ld2affine233 : projective (LD) to affine converter
// ----------------------------------------------------------------------------
module gf2m_ld2affine233 #(
  parameter int M       = 233,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] X,
  input  logic [M-1:0] Y,
  input  logic [M-1:0] Z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] x_aff,
  output logic [M-1:0] y_aff,
  output logic         inf
);

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(MUL_LAT);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INF     = 4'd1,
    S_INV_REQ = 4'd2,
    S_INV_REL = 4'd3,
    S_MUL_X   = 4'd4,
    S_WAIT_X  = 4'd5,
    S_MUL_Y   = 4'd6,
    S_WAIT_Y  = 4'd7,
    S_OUT     = 4'd8
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [M-1:0]  r_x;
  logic [M-1:0]  r_y;
  logic [M-1:0]  r_z;
  logic [M-1:0]  r_zi;
  logic [M-1:0]  r_mul_a;
  logic [M-1:0]  r_mul_b;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_inv_start;
  logic          w_inv_done;
  logic [M-1:0]  w_inv;
  logic [M-1:0]  w_zi_sq;
  logic [M-1:0]  w_prod;

  gf2m_inv233 u_inv (
    .clk   (clk),
    .rst   (rst),
    .start (w_inv_start),
    .a     (r_z),
    .done  (w_inv_done),
    .inv   (w_inv)
  );

  squerer_233 u_sq (
    .a  (r_zi),
    .sq (w_zi_sq)
  );

  gf2m_mult233 #(
    .LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .a   (r_mul_a),
    .b   (r_mul_b),
    .p   (w_prod)
  );

  assign w_accept = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_inv_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (Z == '0) ? S_INF : S_INV_REQ;
        end
      end
      S_INF: begin
        w_next = S_OUT;
      end
      S_INV_REQ: begin
        w_inv_start = 1'b1;
        if (w_inv_done) begin
          w_next = S_INV_REL;
        end
      end
      S_INV_REL: begin
        // The inverter holds done one cycle past start; a new request is
        // only legal once it has dropped.
        if (!w_inv_done) begin
          w_next = S_MUL_X;
        end
      end
      S_MUL_X: begin
        w_next = S_WAIT_X;
      end
      S_WAIT_X: begin
        if (r_cnt == c_CNT_LAST) begin
          w_next = S_MUL_Y;
        end
      end
      S_MUL_Y: begin
        w_next = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        if (r_cnt == c_CNT_LAST) begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zi    <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_cnt   <= '0;
      x_aff   <= '0;
      y_aff   <= '0;
      inf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x <= X;
            r_y <= Y;
            r_z <= Z;
          end
        end
        S_INF: begin
          x_aff <= '0;
          y_aff <= '0;
          inf   <= 1'b1;
        end
        S_INV_REQ: begin
          if (w_inv_done) begin
            r_zi <= w_inv;
          end
        end
        S_MUL_X: begin
          r_mul_a <= r_x;
          r_mul_b <= r_zi;
          r_cnt   <= '0;
        end
        S_WAIT_X: begin
          if (r_cnt == c_CNT_LAST) begin
            x_aff <= w_prod;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MUL_Y: begin
          r_mul_a <= r_y;
          r_mul_b <= w_zi_sq;
          r_cnt   <= '0;
        end
        S_WAIT_Y: begin
          if (r_cnt == c_CNT_LAST) begin
            y_aff <= w_prod;
            inf   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
